// File: rtl/mem_port_arbiter.sv
// Two-port round-robin arbiter in front of a single-ported memory with fixed read latency.
// State | meaning:  IDLE - arbitrate | ISSUE - grant + drive memory | WAIT - read latency countdown
module mem_port_arbiter #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int MEM_LAT = 1
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              req0,
  input  logic              req1,
  input  logic              we0,
  input  logic              we1,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata0,
  input  logic [DATA_W-1:0] wdata1,
  output logic              gnt0,
  output logic              gnt1,
  output logic              rvalid0,
  output logic              rvalid1,
  output logic [DATA_W-1:0] rdata0,
  output logic [DATA_W-1:0] rdata1,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_we,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_e;

  state_e            state_q, state_d;
  logic              port_q, port_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              prio_q, prio_d;
  logic [2:0]        cnt_q, cnt_d;
  logic              rvalid0_q, rvalid0_d;
  logic              rvalid1_q, rvalid1_d;
  logic [DATA_W-1:0] rdata0_q, rdata0_d;
  logic [DATA_W-1:0] rdata1_q, rdata1_d;
  logic              pick;

  always_comb begin
    state_d   = state_q;
    port_d    = port_q;
    we_d      = we_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    prio_d    = prio_q;
    cnt_d     = cnt_q;
    rvalid0_d = 1'b0;
    rvalid1_d = 1'b0;
    rdata0_d  = rdata0_q;
    rdata1_d  = rdata1_q;
    // prio_q names the port that wins a tie; a lone requester always wins
    pick      = (req0 && req1) ? prio_q : req1;
    case (state_q)
      IDLE: begin
        if (req0 || req1) begin
          port_d  = pick;
          we_d    = pick ? we1 : we0;
          addr_d  = pick ? addr1 : addr0;
          wdata_d = pick ? wdata1 : wdata0;
          prio_d  = ~pick;
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        if (we_q) begin
          state_d = IDLE;
        end else begin
          cnt_d   = 3'(MEM_LAT);
          state_d = WAIT;
        end
      end
      WAIT: begin
        cnt_d = cnt_q - 3'd1;
        if (cnt_q == 3'd1) begin
          state_d = IDLE;
          if (port_q) begin
            rdata1_d  = mem_rdata;
            rvalid1_d = 1'b1;
          end else begin
            rdata0_d  = mem_rdata;
            rvalid0_d = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q   <= IDLE;
      port_q    <= 1'b0;
      we_q      <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      prio_q    <= 1'b0;
      cnt_q     <= 3'd0;
      rvalid0_q <= 1'b0;
      rvalid1_q <= 1'b0;
      rdata0_q  <= '0;
      rdata1_q  <= '0;
    end else begin
      state_q   <= state_d;
      port_q    <= port_d;
      we_q      <= we_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      prio_q    <= prio_d;
      cnt_q     <= cnt_d;
      rvalid0_q <= rvalid0_d;
      rvalid1_q <= rvalid1_d;
      rdata0_q  <= rdata0_d;
      rdata1_q  <= rdata1_d;
    end
  end

  // The latch registers double as the memory-side address/data, so they hold in IDLE
  assign gnt0      = (state_q == ISSUE) && !port_q;
  assign gnt1      = (state_q == ISSUE) && port_q;
  assign mem_we    = (state_q == ISSUE) && we_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign busy      = (state_q != IDLE);
  assign rvalid0   = rvalid0_q;
  assign rvalid1   = rvalid1_q;
  assign rdata0    = rdata0_q;
  assign rdata1    = rdata1_q;

endmodule

// File: doc/mem_port_arbiter.md
MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 The block SHALL have parameter ADDR_W, default 32, address width.
REQ-002 The block SHALL have parameter DATA_W, default 32, data width.
REQ-003 The block SHALL have parameter MEM_LAT, default 1, legal 1..4: memory read latency in cycles.
REQ-004 Port clk, input, 1: clock, all state on rising edge.
REQ-005 Port resetn, input, 1: reset, synchronous, active-low.
REQ-006 Ports req0/req1, input, 1 each: transaction request from port 0 (core) / port 1 (DMA).
REQ-007 Ports we0/we1, input, 1 each: 1 = write, 0 = read.
REQ-008 Ports addr0/addr1, input, ADDR_W each: byte address.
REQ-009 Ports wdata0/wdata1, input, DATA_W each: write data.
REQ-010 Ports gnt0/gnt1, output, 1 each: one-cycle grant pulse.
REQ-011 Ports rvalid0/rvalid1, output, 1 each: one-cycle read-data-valid pulse.
REQ-012 Ports rdata0/rdata1, output, DATA_W each: read data, meaningful only with rvalidN.
REQ-013 Port mem_addr, output, ADDR_W: shared memory address.
REQ-014 Port mem_wdata, output, DATA_W: shared memory write data.
REQ-015 Port mem_we, output, 1: shared memory write enable.
REQ-016 Port mem_rdata, input, DATA_W: shared memory read data.
REQ-017 Port busy, output, 1: high whenever state != IDLE.

Function
REQ-018 The FSM SHALL have states IDLE, ISSUE, WAIT.
REQ-019 In IDLE with any reqN high, the block SHALL pick one port, latch its we/addr/wdata and port id, and go to ISSUE next cycle.
REQ-020 Arbitration SHALL be round-robin: on contention, the port not granted most recently wins; after reset, port 0 has priority.
REQ-021 With a single requester, that requester SHALL win regardless of the priority pointer.
REQ-022 In ISSUE, the block SHALL assert gntN of the chosen port for exactly one cycle and drive mem_addr/mem_wdata from the latched values.
REQ-023 mem_we SHALL be high only in the ISSUE cycle of a write.
REQ-024 After a write ISSUE, the next state SHALL be IDLE.
REQ-025 After a read ISSUE, the block SHALL enter WAIT for exactly MEM_LAT cycles, holding mem_addr stable, using a counter loaded with MEM_LAT.
REQ-026 The block SHALL register mem_rdata at the end of the last WAIT cycle into the chosen port's rdataN.
REQ-027 The block SHALL pulse rvalidN for one cycle in the following cycle (state IDLE).
REQ-028 Read latency SHALL be MEM_LAT+1 cycles from gnt to rvalid; write completion SHALL coincide with gnt.
REQ-029 Requesters SHALL hold reqN and payload stable until gntN; payload changes before gnt SHALL be ignored only if the port has already been latched.
REQ-030 reqN still high in the IDLE cycle after completion SHALL be a new request; rvalid and a new arbitration in the same IDLE cycle SHALL both occur.
REQ-031 The round-robin pointer SHALL update on every grant; sustained dual requests SHALL alternate 0,1,0,1.
REQ-032 rdataN SHALL hold its last value between reads; the non-chosen port's rdata SHALL never change.
REQ-033 mem_addr and mem_wdata SHALL hold their last values in IDLE; mem_we SHALL be 0 outside ISSUE.

Reset
REQ-034 With resetn low at a clock edge: state IDLE; priority to port 0; gnt0/1, rvalid0/1, mem_we and busy 0; mem_addr, mem_wdata, rdata0/1 and the latch registers 0.
REQ-035 Reset in ISSUE or WAIT SHALL abort the transaction: no gnt, rvalid or mem_we follows.
REQ-036 After resetn rises, the first arbitration SHALL occur in the first IDLE cycle.

Verification
REQ-037 MEM_LAT=1, req0 read addr 0x100, mem_rdata=0xDEADBEEF -> gnt0 at cycle t, mem_addr=0x100 for t..t+1, rvalid0 with rdata0=0xDEADBEEF at t+2, rdata1 unchanged.
REQ-038 req1 write addr 0x20 data 0x1234 -> gnt1, mem_we=1, mem_addr=0x20, mem_wdata=0x1234 for one cycle, back in IDLE next cycle.
REQ-039 req0 and req1 held high (writes) from reset -> grants 0,1,0,1 each two cycles apart.
REQ-040 MEM_LAT=4, read -> busy high for 5 cycles, rvalid exactly 5 cycles after gnt.
REQ-041 resetn low during WAIT of a port-0 read -> no rvalid0; all outputs at reset values; next req1 served first cycle after reset release.
REQ-042 Only req1 asserted right after reset (priority at port 0) -> gnt1 granted without delay.
